// File: rtl/ps2_host_tx_if.sv
// Command handshake between a byte source and the PS/2 host transmitter.
// The source drives tx_data/tx_valid; the transmitter reports ready/busy and the done/error pulses.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       error;

    modport master (output tx_data, tx_valid, input tx_ready, busy, done, error);
    modport slave  (input tx_data, tx_valid, output tx_ready, busy, done, error);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, device-clocked shift, ack check.
// Define PS2_TX_TIMEOUT_EN to add a watchdog that aborts when the device stops clocking.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe,
    ps2_host_tx_if.slave bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_RTS       = 3'd2;
    localparam logic [2:0] S_WAIT_DEV  = 3'd3;
    localparam logic [2:0] S_SHIFT     = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    localparam int unsigned         INH_W    = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0]    INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    logic             clk_meta_q, clk_sync_q, clk_prev_q;
    logic             data_meta_q, data_sync_q;
    logic [2:0]       state_q, state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       frame_q, frame_d;
    logic             data_oe_q, data_oe_d;

    logic clk_fall;
    logic accept;
    logic shifting;
    logic timeout;

    assign clk_fall = clk_prev_q & ~clk_sync_q;
    assign accept   = (state_q == S_IDLE) & bus.tx_valid;
    assign shifting = (state_q == S_WAIT_DEV) | (state_q == S_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            watching;

    assign watching = shifting | (state_q == S_WAIT_IDLE);
    assign timeout  = watching & (wdog_q == WD_W'(TIMEOUT_CYCLES));

    always_comb begin
        wdog_d = wdog_q;
        if (accept || clk_fall) begin
            wdog_d = '0;
        end else if (watching && !timeout) begin
            wdog_d = wdog_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    // No watchdog: the block waits for the device indefinitely; TIMEOUT_CYCLES has no effect here.
    assign timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        data_oe_d = data_oe_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    frame_d   = {1'b1, ~^bus.tx_data, bus.tx_data};
                    bit_cnt_d = '0;
                    inh_cnt_d = '0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    state_d   = S_RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end
            S_RTS: begin
                state_d = S_WAIT_DEV;
            end
            S_WAIT_DEV, S_SHIFT: begin
                // Frame is shifted out LSB first; falling edge 11 carries the device ack.
                if (clk_fall) begin
                    if (bit_cnt_q < 4'd10) begin
                        data_oe_d = ~frame_q[0];
                        frame_d   = {1'b0, frame_q[9:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        state_d   = S_SHIFT;
                    end else begin
                        bit_cnt_d = 4'd11;
                        state_d   = data_sync_q ? S_IDLE : S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (clk_sync_q && data_sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (timeout) begin
            state_d = S_IDLE;
        end
        if (state_d == S_IDLE) begin
            data_oe_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            inh_cnt_q <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            data_oe_q <= data_oe_d;
        end
    end

    assign ps2_clk_oe  = (state_q == S_INHIBIT) | (state_q == S_RTS);
    assign ps2_data_oe = data_oe_q;

    // Pulses are raised in the last non-idle cycle so tx_ready follows one cycle later.
    assign bus.done     = (state_q == S_WAIT_IDLE) & clk_sync_q & data_sync_q & ~timeout;
    assign bus.error    = timeout | (shifting & clk_fall & (bit_cnt_q >= 4'd10) & data_sync_q);
    assign bus.tx_ready = (state_q == S_IDLE);
    assign bus.busy     = (state_q != S_IDLE);
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to a keyboard over the same open-drain clk/data pair used by the receive path.
- Runs the full inhibit / request-to-send / device-clocked shift / ack sequence.
- Drives the lines only through active-high pull-low enables.
- Instantiated beside the decoder in the top level. The pads implement open-drain behaviour.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before request-to-send (≥100 µs at 50 MHz)
TIMEOUT_CYCLES, 1000000, max clk cycles allowed between device clock edges while busy (see optional feature)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ps2_clk_in  input  1  raw PS/2 clock line level (async; synchronised internally)
ps2_data_in  input  1  raw PS/2 data line level (async; synchronised internally)
ps2_clk_oe  output  1  1 = pull PS/2 clock low
ps2_data_oe  output  1  1 = pull PS/2 data low
tx_data  input  8  byte to send
tx_valid  input  1  request; byte accepted when tx_valid && tx_ready on rising clk
tx_ready  output  1  high only in IDLE
busy  output  1  high in every state except IDLE
done  output  1  1-cycle pulse: transfer finished with device ack
error  output  1  1-cycle pulse: no ack (or timeout)

Behaviour:
- Reset: all outputs 0 except tx_ready=1. State is IDLE. Both oe are deasserted immediately (async); a transfer in flight is abandoned.
- Inputs pass through 2-flop synchronisers. A falling edge is sync_clk previous=1, current=0. Edge detection uses the synchronised value only.
- Accept: latch tx_data. Compute parity as odd parity, par = ~^tx_data. Clear the bit counter. Go to INHIBIT.
- INHIBIT: clk_oe=1, data_oe=0. Count INHIBIT_CYCLES cycles, then go to RTS.
- RTS: clk_oe=1, data_oe=1 (start bit 0) for exactly 1 cycle, then go to WAIT_DEV.
- WAIT_DEV: clk_oe=0, data_oe=1. The host is now passive on clk.
- Shifting uses a frame = {1(stop), par, tx_data[7:0]}, sent LSB first. On each device falling edge n=1..10 while in WAIT_DEV/SHIFT:
  - data_oe <= ~frame[n-1].
  - n=1..8 sends data bits, n=9 sends parity, n=10 releases data (stop).
  - The first edge moves the state to SHIFT.
- 11th falling edge: sample sync_data.
  - 0 = ack: go to WAIT_IDLE.
  - 1: pulse error, go to IDLE.
- WAIT_IDLE: wait until sync_clk=1 && sync_data=1, then pulse done and go to IDLE.
- done and error are mutually exclusive and never asserted in IDLE beyond their single pulse cycle. tx_ready rises the cycle after the pulse.
- tx_valid while busy is ignored. tx_data is not sampled after acceptance.
- The bit counter is 4 bits and saturates at 11; no wrap.

Optional Feature:
PS2_TX_TIMEOUT_EN
- Defined: a watchdog counter of width $clog2(TIMEOUT_CYCLES+1).
  - Resets on acceptance and on every device falling edge.
  - Reaching TIMEOUT_CYCLES in WAIT_DEV, SHIFT or WAIT_IDLE does all of the following: release both lines, pulse error, go to IDLE.
- Undefined: no counter; the block waits indefinitely for device edges.

Test Plan:
- Send 0xF4 with device model clocking at ~12 kHz: clk_oe low 5000 cycles; data bits seen on device rising edges are 0,0,1,0,1,1,1,1, parity 0, stop 1. Device ack 0 → done=1 for 1 cycle, tx_ready=1 next cycle.
- Send 0xED: bits 1,0,1,1,0,1,1,1, parity 1. Device holds data high at 11th edge → error=1 pulse, done stays 0.
- Send 0x00 → parity 1. Send 0xFF → parity 1. Back-to-back tx_valid held high: second byte accepted only after the first done.
- Assert tx_valid with new data during SHIFT: ignored. Transmitted byte unchanged, tx_ready=0 throughout.
- rst_n low mid-SHIFT (bit 4): clk_oe=data_oe=0 asynchronously, busy=0, tx_ready=1. A subsequent 0xF4 transfers correctly.
- With PS2_TX_TIMEOUT_EN and TIMEOUT_CYCLES=1000, device stops after 5 edges → error pulse 1000 cycles after the last edge, lines released. Without the macro the block stays busy.
